branch_resolve_unit: RTL

- ID-stage consumer of the 32-bit equality comparator's `equal` output.
- Decides beq/bne outcome, drives PC select and IF/ID flush, and stalls the front end when a comparator operand is not yet available.
- Keeps saturating branch performance counters.
- Sits between the comparator/forwarding muxes in ID and the PC mux, IF/ID register and ID/EX register.

---
 rtl/branch_resolve_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : ID-stage beq/bne resolution, load/ALU hazard stall and
//            saturating branch performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_beq,
    input  logic             id_bne,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             equal,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_rd,
    output logic             stall,
    output logic             bubble,
    output logic             pc_src,
    output logic             flush_if_id,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] br_taken,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [REG_W-1:0] c_r0      = '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_br_taken;
    logic [CNT_W-1:0] r_stall_cycles;

    logic       w_is_br;
    logic       w_ex_match;
    logic       w_mem_match;
    logic [1:0] w_need;
    logic       w_cond;
    logic       w_stall;
    logic       w_resolve;

    assign w_is_br     = id_beq | id_bne;
    assign w_ex_match  = ex_regwrite & (ex_rd != c_r0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
    assign w_mem_match = mem_memread & (mem_rd != c_r0) & ((mem_rd == id_rs) | (mem_rd == id_rt));
    // beq has priority when both opcodes decode
    assign w_cond      = id_beq ? equal : (id_bne ? ~equal : 1'b0);

    always_comb begin
        w_need = 2'd0;
        if (w_is_br && w_ex_match && ex_memread) begin
            w_need = 2'd2;
        end else if (w_is_br && (w_ex_match || w_mem_match)) begin
            w_need = 2'd1;
        end
    end

    always_comb begin
        stall       = 1'b0;
        bubble      = 1'b0;
        pc_src      = 1'b0;
        flush_if_id = 1'b0;
        if (!reset) begin
            if (r_state == HOLD || w_need != 2'd0) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end else begin
                pc_src      = w_is_br & w_cond;
                flush_if_id = w_is_br & w_cond;
            end
        end
    end

    assign w_stall   = stall;
    assign w_resolve = (r_state == RUN) & w_is_br & (w_need == 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= RUN;
            r_br_count     <= '0;
            r_br_taken     <= '0;
            r_stall_cycles <= '0;
        end else begin
            case (r_state)
                RUN:     r_state <= (w_need == 2'd2) ? HOLD : RUN;
                HOLD:    r_state <= RUN;
                default: r_state <= RUN;
            endcase
            if (w_resolve && r_br_count != c_cnt_max) begin
                r_br_count <= r_br_count + 1'b1;
            end
            if (w_resolve && w_cond && r_br_taken != c_cnt_max) begin
                r_br_taken <= r_br_taken + 1'b1;
            end
            if (w_stall && r_stall_cycles != c_cnt_max) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign br_count     = r_br_count;
    assign br_taken     = r_br_taken;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
